// File: rtl/spi_phase_sequencer.sv
// Phase-code sequencer feeding the SPI/SRAM control decoder: walks phases 1..LAST_PHASE, two clocks each.
// Optional stall input is compiled in when PHASE_STALL_EN is defined.
module spi_phase_sequencer #(
  parameter int LAST_PHASE = 20,
  parameter int IDLE_GAP   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
`ifdef PHASE_STALL_EN
  input  logic stall,
`endif
  output logic in1,
  output logic in2,
  output logic in3,
  output logic in4,
  output logic in5,
  output logic cout,
  output logic ready,
  output logic busy,
  output logic done,
  output logic aborted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  localparam logic [4:0] LAST_P = 5'(LAST_PHASE);
  localparam logic [3:0] GAP_N  = 4'(IDLE_GAP);

  state_t     state_q, state_d;
  logic [4:0] phase_q, phase_d;
  logic       cout_q, cout_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;
  logic [3:0] gap_q, gap_d;
  logic       stall_w;

`ifdef PHASE_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cout_q    <= cout_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cout_d    = cout_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        cout_d  = 1'b0;
        gap_d   = '0;
        if (start) begin
          state_d   = S_RUN;
          phase_d   = 5'd1;
          aborted_d = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall_w) begin
          // Abort jumps straight to the cleanup phase so it still gets its full two clocks.
          if (abort && (phase_q < LAST_P)) begin
            phase_d   = LAST_P;
            cout_d    = 1'b0;
            aborted_d = 1'b1;
          end else if (!cout_q) begin
            cout_d = 1'b1;
          end else if (phase_q < LAST_P) begin
            phase_d = phase_q + 5'd1;
            cout_d  = 1'b0;
          end else begin
            phase_d = '0;
            cout_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_GAP;
            gap_d   = 4'd1;
          end
        end
      end
      S_GAP: begin
        // gap_q already counts the done cycle as the first gap clock.
        if (gap_q >= GAP_N) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {in1, in2, in3, in4, in5} = phase_q;
  assign cout    = cout_q;
  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_RUN);
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: doc/spi_phase_sequencer.md
Name: spi_phase_sequencer

Overview:
- Sequential stage directly upstream of the SPI/SRAM control decoder.
- Generates the 5-bit transaction phase code (in1..in5) and the half-bit strobe cout that the decoder turns into address, command, Rx, Tx and slave-select controls.
- Steps one SPI transaction per accepted start: idle code 0, then codes 1..LAST_PHASE, then back to 0.
- Supports abort-to-cleanup and an enforced idle gap between transactions.

Parameters:
- LAST_PHASE, 20: final phase code; Tx cleanup phase. Legal range 2..31.
- IDLE_GAP, 2: minimum clocks spent in phase 0 after a transaction before the next start is accepted. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a transaction; sampled only while ready=1.
- abort  input  1  request early termination; sampled only in RUN.
- in1  output  1  phase code bit 4 (MSB).
- in2  output  1  phase code bit 3.
- in3  output  1  phase code bit 2.
- in4  output  1  phase code bit 1.
- in5  output  1  phase code bit 0 (LSB).
- cout  output  1  half-bit strobe: 0 in the first clock of each phase, 1 in the second.
- ready  output  1  idle and able to accept start.
- busy  output  1  transaction in progress (phase code non-zero).
- done  output  1  one-cycle pulse when phase returns to 0.
- aborted  output  1  sticky flag: last transaction was cut short by abort; cleared on the next accepted start.
- stall  input  1  present only with PHASE_STALL_EN; freezes the sequencer.

Behaviour:
- Reset, synchronous: phase=0, cout=0, busy=0, done=0, aborted=0, gap counter=0, state=IDLE, ready=1 in the cycle after reset.
- Phase code: 5-bit register, {in1,in2,in3,in4,in5} = phase[4:0].
- States: IDLE, RUN, GAP.
- IDLE:
  - phase=0, cout=0, ready=1.
  - start=1 → next cycle phase=1, cout=0, state=RUN, busy=1, aborted=0.
- RUN:
  - Each phase lasts exactly 2 clocks: cout=0, then cout=1.
  - On a cout=1 cycle with phase<LAST_PHASE: next cycle phase+1, cout=0.
  - On a cout=1 cycle with phase=LAST_PHASE: next cycle phase=0, cout=0, busy=0, done=1, state=GAP.
  - Latency: start sampled at edge T → phase k with cout=0 at T+2k-1 and cout=1 at T+2k; done at T+2*LAST_PHASE+1.
- Abort:
  - abort=1 in RUN with phase<LAST_PHASE, either cout value → next cycle phase=LAST_PHASE, cout=0, aborted=1.
  - LAST_PHASE then completes normally (2 clocks), then done.
  - abort while phase=LAST_PHASE: ignored, aborted unchanged.
  - abort in IDLE or GAP: ignored.
- GAP:
  - phase=0, ready=0, start ignored.
  - Gap counter counts IDLE_GAP cycles, starting with the done cycle.
  - After IDLE_GAP cycles → IDLE, ready=1.
  - done is high only in the first GAP cycle.
- Simultaneous events:
  - start together with abort in IDLE: start accepted, abort ignored.
  - rst overrides everything, including mid-transaction; phase forced to 0 with no done pulse.
- cout=0 whenever phase=0.
- Phase arithmetic: 5-bit, never wraps; LAST_PHASE caps it.

Optional Feature:
- Macro: PHASE_STALL_EN.
- Defined:
  - stall input exists.
  - stall=1 in RUN holds phase, cout and state for that cycle; no advance, no abort acceptance.
  - stall has no effect in IDLE or GAP.
  - Latency extends by one clock per stalled cycle.
- Undefined: no stall port; behaviour as above.

Test Plan:
- Reset: assert rst 3 cycles mid-RUN at phase 7 → next cycle phase=0, cout=0, busy=0, ready=1, done never pulses.
- Full transaction: start at T with defaults →
  - phase 1/cout 0 at T+1; phase 1/cout 1 at T+2;
  - phase 10/cout 0 at T+19; phase 20/cout 1 at T+40;
  - phase 0 and done=1 at T+41; ready=1 at T+43.
- Gap enforcement: hold start=1 continuously → second transaction's phase 1 appears at T+44, not earlier.
- Abort: abort=1 in phase 12, cout=1 → next cycle phase=20/cout=0, then phase 20/cout=1, then done=1 with aborted=1; aborted clears on next start.
- Abort at LAST_PHASE and in IDLE: both ignored; aborted stays 0; timing identical to the full transaction.
- With PHASE_STALL_EN: stall=1 for 3 cycles at phase 5/cout=0 → phase 5/cout=0 held 4 cycles total; done arrives 3 cycles later than T+41.
